// File: rtl/bram_arbiter_pkg.sv
// Shared definitions for the frame-buffer arbiter and its TX/RX neighbours.
// Holds the arbiter state encoding and the default BRAM address/pixel widths.
// No logic lives here; import with bram_arbiter_pkg::*.
package bram_arbiter_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWEEP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bram_arbiter_if.sv
// Bundle of every signal the arbiter exchanges with TX fetch, RX capture and the BRAM.
// slave: the arbiter's view (requests and BRAM read data in, grants/status out).
// master: the clients' view (TX, RX, clear control and the BRAM model).
interface bram_arbiter_if
    import bram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              TX_RD_EN;
    logic [ADDR_W-1:0] TX_ADDR;
    logic [DATA_W-1:0] TX_DOUT;
    logic              TX_DVALID;
    logic              RX_WR_VALID;
    logic              RX_WR_READY;
    logic [ADDR_W-1:0] RX_WR_ADDR;
    logic [DATA_W-1:0] RX_WR_DATA;
    logic              CLEAR_REQ;
    logic              CLEAR_BUSY;
    logic              CLEAR_DONE;
    logic [LVL_W-1:0]  FIFO_LEVEL;
    logic [ADDR_W-1:0] BRAM_ADDR;
    logic [DATA_W-1:0] BRAM_DIN;
    logic              BRAM_WE;
    logic [DATA_W-1:0] BRAM_DOUT;

    modport slave (
        input  TX_RD_EN, TX_ADDR, RX_WR_VALID, RX_WR_ADDR, RX_WR_DATA, CLEAR_REQ, BRAM_DOUT,
        output TX_DOUT, TX_DVALID, RX_WR_READY, CLEAR_BUSY, CLEAR_DONE, FIFO_LEVEL,
               BRAM_ADDR, BRAM_DIN, BRAM_WE
    );

    modport master (
        output TX_RD_EN, TX_ADDR, RX_WR_VALID, RX_WR_ADDR, RX_WR_DATA, CLEAR_REQ, BRAM_DOUT,
        input  TX_DOUT, TX_DVALID, RX_WR_READY, CLEAR_BUSY, CLEAR_DONE, FIFO_LEVEL,
               BRAM_ADDR, BRAM_DIN, BRAM_WE
    );

endinterface

// File: rtl/bram_arbiter_sync_fifo.sv
// Generic synchronous FIFO (sync_fifo): push/pop, full/empty flags and occupancy level.
// Latency: a pushed entry is visible at o_dout on the cycle after the push.
// Backpressure: caller must not push when full nor pop when empty; DEPTH must be a power of 2.
module bram_arbiter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // Storage needs no reset: only entries below the level are ever read.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/bram_arbiter.sv
// Single-port BRAM arbiter: TX reads > clear sweep writes > buffered RX writes, one access/cycle.
// Latency: TX read data one cycle after request (same as a direct BRAM); RX writes retire >= 1 cycle after accept.
// Backpressure: TX never stalled; RX_WR_READY drops when the write FIFO is full or a clear is running.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                MEM_DEPTH   = 16384,
    parameter int                FIFO_DEPTH  = 4,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input logic              CLK,
    input logic              RESET_N,
    bram_arbiter_if.slave    bus
);

    localparam int                LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_sweep_cnt;
    logic              r_tx_dvalid;
    logic              r_rdy_en;

    wr_ent_t           w_push_ent;
    wr_ent_t           w_head;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [LVL_W-1:0]  w_level;

    logic              w_rx_rdy;
    logic              w_clr_gnt;
    logic              w_fifo_gnt;
    logic              w_sweep_last;
    logic [ADDR_W-1:0] w_bram_addr;
    logic [DATA_W-1:0] w_bram_din;
    logic              w_bram_we;

    assign w_push_ent = '{addr: bus.RX_WR_ADDR, data: bus.RX_WR_DATA};
    assign w_push     = bus.RX_WR_VALID && w_rx_rdy;

    bram_arbiter_sync_fifo #(
        .WIDTH ($bits(wr_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_push  (w_push),
        .i_din   (w_push_ent),
        .i_pop   (w_fifo_gnt),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // State register; r_rdy_en keeps RX_WR_READY low while reset is asserted.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= ST_IDLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rdy_en <= 1'b1;
        end
    end

    // Next state: a clear first drains queued writes so they cannot land on top of the sweep.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.CLEAR_REQ) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_empty)       w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (w_sweep_last)  w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs/grants: TX always wins; sweep and FIFO only use cycles TX leaves free.
    always_comb begin
        w_rx_rdy     = r_rdy_en && (r_state == ST_IDLE) && !w_full;
        w_clr_gnt    = (r_state == ST_SWEEP) && !bus.TX_RD_EN;
        w_fifo_gnt   = (r_state != ST_SWEEP) && !bus.TX_RD_EN && !w_empty;
        w_sweep_last = w_clr_gnt && (r_sweep_cnt == LAST_ADDR);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sweep_cnt <= '0;
            r_tx_dvalid <= 1'b0;
        end else begin
            r_tx_dvalid <= bus.TX_RD_EN;
            if (w_clr_gnt) begin
                r_sweep_cnt <= w_sweep_last ? '0 : r_sweep_cnt + 1'b1;
            end
        end
    end

    // BRAM port mux; an idle bus is driven to all zeros.
    always_comb begin
        w_bram_addr = '0;
        w_bram_din  = '0;
        w_bram_we   = 1'b0;
        if (bus.TX_RD_EN) begin
            w_bram_addr = bus.TX_ADDR;
        end else if (w_clr_gnt) begin
            w_bram_addr = r_sweep_cnt;
            w_bram_din  = CLEAR_VALUE;
            w_bram_we   = 1'b1;
        end else if (w_fifo_gnt) begin
            w_bram_addr = w_head.addr;
            w_bram_din  = w_head.data;
            w_bram_we   = 1'b1;
        end
    end

    assign bus.BRAM_ADDR   = w_bram_addr;
    assign bus.BRAM_DIN    = w_bram_din;
    assign bus.BRAM_WE     = w_bram_we;
    assign bus.TX_DOUT     = bus.BRAM_DOUT;
    assign bus.TX_DVALID   = r_tx_dvalid;
    assign bus.RX_WR_READY = w_rx_rdy;
    assign bus.CLEAR_BUSY  = (r_state != ST_IDLE);
    assign bus.CLEAR_DONE  = w_sweep_last;
    assign bus.FIFO_LEVEL  = w_level;

endmodule

// File: tb/tb_bram_arbiter.sv
module tb_bram_arbiter;
    import bram_arbiter_pkg::*;

    localparam int AW    = 14;
    localparam int DW    = 8;
    localparam int DEPTH = 16384;
    localparam int FD    = 4;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b1;

    bram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) bus();

    bram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .FIFO_DEPTH(FD), .CLEAR_VALUE(8'h00)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    // Physical BRAM: synchronous, read-first, driven only by the DUT's port.
    logic [DW-1:0] bram [DEPTH] = '{default: '0};
    always @(posedge CLK) begin
        if (bus.BRAM_WE) bram[bus.BRAM_ADDR] <= bus.BRAM_DIN;
        bus.BRAM_DOUT <= bram[bus.BRAM_ADDR];
    end

    // Reference model: queue of accepted writes, clear phase, and the memory image the spec implies.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] refm [DEPTH] = '{default: '0};
    int            phase;      // 0 idle, 1 draining, 2 sweeping
    int            sweep_ptr;
    bit            rd_pend;
    logic [DW-1:0] rd_exp;
    bit            ready_ok;
    int            vectors;
    int            errors;
    int            done_cnt;
    int            acc_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit tx, input int taddr, input bit vld, input int raddr,
                         input int rdat, input bit clr);
        bus.TX_RD_EN    = tx;
        bus.TX_ADDR     = AW'(taddr);
        bus.RX_WR_VALID = vld;
        bus.RX_WR_ADDR  = AW'(raddr);
        bus.RX_WR_DATA  = DW'(rdat);
        bus.CLEAR_REQ   = clr;
    endtask

    // One clock: compare at the falling edge, advance the model, return 1 time unit after the rising edge.
    task automatic tick();
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        bit e_we, e_done, e_rdy, fifo_w, clr_w, was_empty;
        int old_phase;
        @(negedge CLK);
        e_rdy  = ready_ok && (phase == 0) && (q.size() < FD);
        e_we   = 1'b0; e_addr = '0; e_din = '0; e_done = 1'b0; fifo_w = 1'b0; clr_w = 1'b0;
        if (bus.TX_RD_EN) begin
            e_addr = bus.TX_ADDR;
        end else if (phase == 2) begin
            clr_w = 1'b1; e_we = 1'b1; e_addr = AW'(sweep_ptr); e_din = 8'h00;
            e_done = (sweep_ptr == DEPTH - 1);
        end else if (q.size() > 0) begin
            fifo_w = 1'b1; e_we = 1'b1; e_addr = q[0].addr; e_din = q[0].data;
        end
        chk("bram_we",     32'(bus.BRAM_WE),     32'(e_we));
        chk("bram_addr",   32'(bus.BRAM_ADDR),   32'(e_addr));
        chk("bram_din",    32'(bus.BRAM_DIN),    32'(e_din));
        chk("rx_ready",    32'(bus.RX_WR_READY), 32'(e_rdy));
        chk("fifo_level",  32'(bus.FIFO_LEVEL),  32'(q.size()));
        chk("clear_busy",  32'(bus.CLEAR_BUSY),  32'(phase != 0));
        chk("clear_done",  32'(bus.CLEAR_DONE),  32'(e_done));
        chk("tx_dvalid",   32'(bus.TX_DVALID),   32'(rd_pend));
        if (rd_pend) chk("tx_dout", 32'(bus.TX_DOUT), 32'(rd_exp));
        if (bus.RX_WR_VALID && bus.RX_WR_READY) acc_cnt++;
        if (bus.CLEAR_DONE) done_cnt++;

        rd_pend = bus.TX_RD_EN;
        if (bus.TX_RD_EN) rd_exp = refm[bus.TX_ADDR];
        was_empty = (q.size() == 0);
        old_phase = phase;
        if (e_we)   refm[e_addr] = e_din;
        if (fifo_w) void'(q.pop_front());
        if (clr_w)  sweep_ptr = e_done ? 0 : sweep_ptr + 1;
        if (e_rdy && bus.RX_WR_VALID) q.push_back('{addr: bus.RX_WR_ADDR, data: bus.RX_WR_DATA});
        case (old_phase)
            0: if (bus.CLEAR_REQ) phase = 1;
            1: if (was_empty)     phase = 2;
            2: if (e_done)        phase = 0;
            default: phase = 0;
        endcase
        @(posedge CLK);
        #1;
    endtask

    // Assert reset mid-cycle, check every output is zero at once, then release and resync the model.
    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_tx_dvalid",  32'(bus.TX_DVALID),   32'd0);
        chk("rst_clear_busy", 32'(bus.CLEAR_BUSY),  32'd0);
        chk("rst_clear_done", 32'(bus.CLEAR_DONE),  32'd0);
        chk("rst_bram_we",    32'(bus.BRAM_WE),     32'd0);
        chk("rst_bram_addr",  32'(bus.BRAM_ADDR),   32'd0);
        chk("rst_bram_din",   32'(bus.BRAM_DIN),    32'd0);
        chk("rst_rx_ready",   32'(bus.RX_WR_READY), 32'd0);
        chk("rst_fifo_level", 32'(bus.FIFO_LEVEL),  32'd0);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        q.delete();
        phase = 0; sweep_ptr = 0; rd_pend = 1'b0; ready_ok = 1'b1;
    endtask

    initial begin
        vectors = 0; errors = 0; done_cnt = 0; acc_cnt = 0;
        phase = 0; sweep_ptr = 0; rd_pend = 1'b0; rd_exp = '0; ready_ok = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        do_reset();
        tick();
        tick();

        // TX hogs the port: exactly FIFO_DEPTH writes accepted, none retired.
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, $urandom_range(0, DEPTH - 1), 1, 'h10 + acc_cnt, 'hAA + acc_cnt, 0);
            tick();
        end
        chk("tx_prio_accepts", 32'(acc_cnt), 32'd4);
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) tick();

        // Preload 0x0123 through RX, then read it back.
        drive(0, 0, 1, 'h123, 'h5C, 0); tick();
        drive(0, 0, 0, 0, 0, 0);        tick();
        drive(1, 'h123, 0, 0, 0, 0);    tick();
        chk("rd_0123_dvalid", 32'(bus.TX_DVALID), 32'd1);
        chk("rd_0123_dout",   32'(bus.TX_DOUT),   32'h5C);

        // Simultaneous push and pop at level 2.
        drive(1, 'h010, 1, 'h200, 'h11, 0); tick();
        drive(1, 'h011, 1, 'h201, 'h22, 0); tick();
        drive(0, 0, 1, 'h202, 'h33, 0);     tick();
        chk("push_pop_level", 32'(bus.FIFO_LEVEL), 32'd2);
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) tick();

        // Clear with three queued writes; a second request mid-sweep must be ignored.
        for (int i = 0; i < 3; i++) begin
            drive(1, 'h300 + i, 1, 'h300 + i, 'hC0 + i, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1); tick();
        done_cnt = 0;
        for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
            drive(0, 0, (i < 10), 'h3F0, 'hEE, (i == 100));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (5) tick();
        chk("clear1_done_pulses", 32'(done_cnt), 32'd1);

        // Random mixed traffic over a small address window so reads hit recent writes.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1),
                  $urandom_range(0, 63), $urandom_range(0, 255), 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) tick();

        // Reset mid-sweep aborts the clear without a done pulse.
        drive(0, 0, 0, 0, 0, 1); tick();
        done_cnt = 0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (40) tick();
        do_reset();
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Clear interleaved with 50% TX reads at random addresses.
        drive(0, 0, 0, 0, 0, 1); tick();
        done_cnt = 0;
        for (int i = 0; i < 40000 && done_cnt == 0; i++) begin
            drive(i[0], $urandom_range(0, DEPTH - 1), 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        chk("clear2_done_pulses", 32'(done_cnt), 32'd1);
        chk("clear2_idle_busy",   32'(bus.CLEAR_BUSY), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
